dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge between the single-cycle CPU core's load/store port and a multi-cycle data memory with a request/grant/response handshake. Converts each CPU access into one memory transaction and drives the core's `stall` input until the access completes. The core holds its instruction and re-presents the same request every stalled cycle. Also keeps a stall-cycle counter for performance measurement.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; `DW/8` byte strobes

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_re`  in  1  load request, held while `stall`=1
- `cpu_we`  in  1  store request, held while `stall`=1; `cpu_re` and `cpu_we` are never both 1
- `cpu_addr`  in  AW  byte address
- `cpu_wdata`  in  DW  store data
- `cpu_wstrb`  in  DW/8  store byte enables
- `cpu_rdata`  out  DW  load data, valid only in the DONE cycle
- `stall`  out  1  freeze the core (PC/regfile/CSR writes suppressed)
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1 = write
- `mem_addr`  out  AW  `{cpu_addr[AW-1:2], 2'b00}`
- `mem_wdata`  out  DW  write data
- `mem_wstrb`  out  DW/8  write strobes; all 0 for reads
- `mem_gnt`  in  1  request accepted this cycle (sampled only while `mem_req`=1)
- `mem_rvalid`  in  1  read data valid; at least 1 cycle after the read's `mem_gnt`
- `mem_rdata`  in  DW  read data
- `stall_cnt`  out  32  cycles with `stall`=1 since reset; wraps at 2^32

## Operation
- State machine:
  - **IDLE**: on `cpu_re|cpu_we`, latch address, data, strobes and direction, then go to REQ.
  - **REQ**: `mem_req`=1. On `mem_gnt`, a read goes to WAIT and a write goes to DONE.
  - **WAIT**: on `mem_rvalid`, capture `mem_rdata` into `rdata_q` and go to DONE.
  - **DONE**: go to IDLE unconditionally.
- `stall` (combinational) = (`cpu_re|cpu_we`) && state≠DONE. It is 0 in IDLE with no request.
- `cpu_rdata` = `rdata_q`. It holds its last value outside DONE; reset value 0.
- From DONE the FSM returns to IDLE, so the next access by the core (new instruction) is a fresh transaction. There is no back-to-back without an IDLE cycle.
- `mem_rvalid` is ignored in IDLE, REQ and DONE, so a stray response after reset is dropped.
- `mem_gnt` is ignored when `mem_req`=0.
- `stall_cnt` increments on each clock edge where `stall`=1.
- The CPU-side inputs are not re-sampled after IDLE; latched values drive the memory side.

## Timing
- Reset values: state=IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `rdata_q`=0, `stall_cnt`=0, write buffer empty.
- `stall` with no request pending during reset is 0.
- Load, request in cycle N:
  - N is IDLE (`stall`=1); N+1 is REQ.
  - With `mem_gnt` in N+1 and `mem_rvalid` in N+2, DONE is in N+3 (`stall`=0) and the core commits at the end of N+3.
  - Minimum: 3 stalled cycles, plus 1 per extra grant-wait or response-wait cycle.
- Store, `mem_gnt` in N+1: DONE in N+2. Minimum 2 stalled cycles.
- `rst` in any state returns the FSM to IDLE on the next edge and drops `mem_req` that edge. An in-flight transaction is abandoned and not retried.

## Configuration
- `DMEM_WBUF_EN` defined adds a one-entry posted write buffer:
  - A store seen in IDLE with the buffer empty is latched into the buffer with `stall`=0 that cycle (zero-stall store).
  - The buffer drains through REQ in the background while the FSM otherwise stays available; it empties on `mem_gnt`.
  - Any load or store seen while the buffer is occupied stalls until the buffer empties, then proceeds as normal. A load therefore never bypasses a pending store.
- Undefined: no buffer; stores behave as in Operation/Timing.

## Test plan
- Load `cpu_addr`=0x0000_0104, `mem_gnt` immediate, `mem_rvalid` 1 cycle later with 0xDEADBEEF -> `mem_addr`=0x104, `mem_wstrb`=0, `stall`=1 for 3 cycles, `cpu_rdata`=0xDEADBEEF in DONE, `stall_cnt`=3.
- Store 0x12345678, strobe 0b0011, to 0x0000_0206, `mem_gnt` delayed 2 cycles -> `mem_addr`=0x204, `mem_wstrb`=0b0011, `stall`=1 for 4 cycles, one `mem_req` transaction only.
- Load with `mem_rvalid` delayed 5 cycles; a spurious `mem_rvalid` asserted in IDLE beforehand -> spurious response ignored, `stall`=1 for 7 cycles, correct data returned.
- `rst` asserted in WAIT, then `mem_rvalid` arrives -> next cycle IDLE, `mem_req`=0, `stall_cnt`=0, `cpu_rdata`=0, response dropped.
- With `DMEM_WBUF_EN`: store then immediate load, memory grant delayed 3 cycles -> store `stall`=0 in its cycle; load stalls until the write is granted; the memory sees the write strictly before the read.

Source files
------------

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - CPU load/store port to request/grant/response data-memory bridge
// Optional posted write buffer enabled by defining DMEM_WBUF_EN.
module dmem_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    input  logic [DW/8-1:0]   cpu_wstrb,
    output logic [DW-1:0]     cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata,
    output logic [31:0]       stall_cnt
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic            cpu_req;
`ifdef DMEM_WBUF_EN
    logic            wbuf_q, wbuf_d;
`endif

    assign cpu_req = cpu_re | cpu_we;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rdata_d     = rdata_q;
        stall       = 1'b0;
`ifdef DMEM_WBUF_EN
        wbuf_d      = wbuf_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef DMEM_WBUF_EN
                // The buffered write owns the memory port; everything else waits for it to drain.
                if (wbuf_q) begin
                    stall = cpu_req;
                    if (mem_gnt) begin
                        wbuf_d    = 1'b0;
                        mem_req_d = 1'b0;
                    end
                end else if (cpu_we) begin
                    mem_addr_d  = {cpu_addr[AW-1:2], 2'b00};
                    mem_we_d    = 1'b1;
                    mem_wdata_d = cpu_wdata;
                    mem_wstrb_d = cpu_wstrb;
                    mem_req_d   = 1'b1;
                    wbuf_d      = 1'b1;
                end else if (cpu_re) begin
                    stall       = 1'b1;
                    mem_addr_d  = {cpu_addr[AW-1:2], 2'b00};
                    mem_we_d    = 1'b0;
                    mem_wdata_d = cpu_wdata;
                    mem_wstrb_d = '0;
                    mem_req_d   = 1'b1;
                    state_d     = S_REQ;
                end
`else
                stall = cpu_req;
                if (cpu_req) begin
                    mem_addr_d  = {cpu_addr[AW-1:2], 2'b00};
                    mem_we_d    = cpu_we;
                    mem_wdata_d = cpu_wdata;
                    mem_wstrb_d = cpu_we ? cpu_wstrb : '0;
                    mem_req_d   = 1'b1;
                    state_d     = S_REQ;
                end
`endif
            end
            S_REQ: begin
                stall = cpu_req;
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = cpu_req;
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stall_cnt_d = stall_cnt_q + {31'b0, stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rdata_q     <= '0;
            stall_cnt_q <= '0;
`ifdef DMEM_WBUF_EN
            wbuf_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rdata_q     <= rdata_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef DMEM_WBUF_EN
            wbuf_q      <= wbuf_d;
`endif
        end
    end

    assign cpu_rdata = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - randomized self-checking bench for dmem_bridge with a memory-model agent
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] stall_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt;
    logic [31:0] mem_model [int unsigned];

    always #5 clk = ~clk;

    dmem_bridge #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned w = a >> 2;
        if (mem_model.exists(w)) return mem_model[w];
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur = model_read(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        mem_model[a >> 2] = cur;
    endtask

    // Idle cycles with junk on the memory response side, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_re     = 1'b0;
            cpu_we     = 1'b0;
            mem_gnt    = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            #1;
            check("idle_stall", {31'b0, stall}, 32'd0);
            check("idle_req", {31'b0, mem_req}, 32'd0);
            @(posedge clk);
        end
    endtask

    // One CPU access; gd = cycles of mem_req before grant, rd = cycles from grant to rvalid.
    task automatic access(input bit is_load, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int gd, input int rd);
        int          cyc, reqc, gnt_cyc, stalled, grants, exp_stall;
        bit          granted, rv_done, done;
        logic [31:0] exp_rd;
        cyc = 0; reqc = 0; gnt_cyc = 0; stalled = 0; grants = 0;
        granted = 0; rv_done = 0; done = 0;
        exp_rd = model_read(addr);
        exp_stall = is_load ? (2 + gd + rd) : (2 + gd);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cpu_re     = is_load;
            cpu_we     = !is_load;
            cpu_addr   = addr;
            cpu_wdata  = wdata;
            cpu_wstrb  = wstrb;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (is_load && granted && !rv_done && cyc == gnt_cyc + rd) begin
                mem_rvalid = 1'b1;
                mem_rdata  = exp_rd;
                rv_done    = 1;
            end
            if (mem_req) begin
                if (reqc == gd) begin
                    mem_gnt = 1'b1;
                    grants++;
                    granted = 1;
                    gnt_cyc = cyc;
                    check("gnt_addr", mem_addr, {addr[31:2], 2'b00});
                    check("gnt_we", {31'b0, mem_we}, {31'b0, !is_load});
                    check("gnt_wstrb", {28'b0, mem_wstrb}, is_load ? 32'd0 : {28'b0, wstrb});
                    if (!is_load) begin
                        check("gnt_wdata", mem_wdata, wdata);
                        model_write(addr, wdata, wstrb);
                    end
                end
                reqc++;
            end
            #1;
            if (stall) stalled++;
            else begin
                done = 1;
                check("done_req", {31'b0, mem_req}, 32'd0);
                if (is_load) check("rdata", cpu_rdata, exp_rd);
            end
            @(posedge clk);
            cyc++;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        exp_cnt = exp_cnt + exp_stall;
        check("stall_cycles", stalled, exp_stall);
        check("grant_count", grants, 32'd1);
        check("req_cycles", reqc, gd + 1);
        check("stall_cnt", stall_cnt, exp_cnt);
    endtask

    initial begin
        rst = 1'b1; cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        rst = 1'b0;
        @(posedge clk);

        mem_model[32'h104 >> 2] = 32'hDEADBEEF;
        access(1, 32'h0000_0104, 32'h0, 4'h0, 0, 1);
        idle(2);
        access(0, 32'h0000_0206, 32'h1234_5678, 4'b0011, 2, 0);
        idle(3);
        access(1, 32'h0000_0206, 32'h0, 4'h0, 0, 5);

        for (int i = 0; i < 60; i++) begin
            access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        // Reset while waiting for a read response; the late response must be dropped.
        @(negedge clk);
        cpu_re = 1; cpu_we = 0; cpu_addr = 32'h40; mem_gnt = 0; mem_rvalid = 0;
        @(posedge clk);
        @(negedge clk);
        check("rw_req", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1;
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 0; rst = 1;
        #1;
        check("rw_wait_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 0; cpu_re = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        #1;
        check("rw_stall", {31'b0, stall}, 32'd0);
        check("rw_req_drop", {31'b0, mem_req}, 32'd0);
        check("rw_cnt", stall_cnt, 32'd0);
        check("rw_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 0;
        #1;
        check("rw_rdata_after", cpu_rdata, 32'd0);
        check("rw_cnt_after", stall_cnt, 32'd0);
        @(posedge clk);
        exp_cnt = 0;
        access(1, 32'h0000_0040, 32'h0, 4'h0, 1, 2);
        access(0, 32'h0000_0044, 32'hA5A5_5A5A, 4'b1100, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
